cb_rd_sched: RTL and testbench

- Sequences port A of the coefficient buffer (CB) among three operand fetchers: A-operand, B-operand and M-operand.
- Arbitrates requests and issues burst reads (CB_ena/CB_addra).
- Drives the 4-bit douta mapping select, time-aligned with the returning read data.
- Flags when mapped data appears at the A/B/M mapper outputs.

---
 rtl/cb_rd_sched.sv | 212 +++++++++++++++++++++
 tb/tb_cb_rd_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_rd_sched.sv
// -----------------------------------------------------------------------------
// cb_rd_sched
// Sequences coefficient-buffer port A among three operand fetchers
// (A = index 0, B = index 1, M = index 2). One transaction is in flight at a
// time: grant, burst of reads, drain while read data and the registered mapper
// output retire, then a one-cycle done pulse to the fetcher.
//
// Optional feature (macro CB_RD_SCHED_M_PRIO_EN):
//   defined   : M has strict priority; A/B round-robin between themselves.
//   undefined : three-way round robin starting at rr.
//
// Ports:
//   clk, sys_rst_n      clock, asynchronous active-low reset
//   req[2:0]            request per fetcher
//   req_addr/len/dir    per-fetcher base address, burst length, map direction
//   gnt[2:0]            one-hot grant held for the whole transaction
//   done[2:0]           one-cycle completion pulse
//   CB_ena, CB_addra    port-A read enable / address
//   CB_douta_sel[3:0]   {target, direction}, aligned to returning read data
//   out_vld[2:0]        mapped word present at the target mapper output
//   busy                state != IDLE
//   dbg_state[1:0]      FSM state (IDLE=0, BURST=1, DRAIN=2)
//
// Handshake: req is a level request sampled only in IDLE; fields are latched
// at grant and ignored afterwards; done closes the transaction.
// -----------------------------------------------------------------------------
module cb_rd_sched #(
    parameter int CB_AW  = 10,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic [2:0]           req,
    input  logic [3*CB_AW-1:0]   req_addr,
    input  logic [3*LEN_W-1:0]   req_len,
    input  logic [5:0]           req_dir,
    output logic [2:0]           gnt,
    output logic [2:0]           done,
    output logic                 CB_ena,
    output logic [CB_AW-1:0]     CB_addra,
    output logic [3:0]           CB_douta_sel,
    output logic [2:0]           out_vld,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [DW-1:0] DLAST = DW'(RD_LAT);

    typedef struct packed {
        logic       vld;
        logic [2:0] tgt;
        logic [3:0] sel;
    } pipe_t;

    state_t           state;
    logic [1:0]       rr;
    logic [1:0]       w_q;
    logic [CB_AW-1:0] base_q;
    logic [LEN_W-1:0] len_q;
    logic [1:0]       dir_q;
    logic [LEN_W-1:0] cnt;
    logic [DW-1:0]    dcnt;

    logic             win_vld;
    logic [1:0]       win;
    logic [CB_AW-1:0] win_addr;
    logic [LEN_W-1:0] win_len;
    logic [1:0]       win_dir;
    logic [3:0]       s0_sel;
    pipe_t            pipe [1:RD_LAT+1];

    // Arbitration: pick a winner among the requesting fetchers.
    always_comb begin
        win_vld = |req;
        win     = 2'd0;
`ifdef CB_RD_SCHED_M_PRIO_EN
        // rr only ever holds 0 (A first) or 1 (B first) in this mode.
        if (req[2])
            win = 2'd2;
        else if (req[rr[0]])
            win = {1'b0, rr[0]};
        else
            win = {1'b0, ~rr[0]};
`else
        begin
            logic [1:0] c0, c1, c2;
            c0 = rr;
            c1 = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
            c2 = (rr == 2'd0) ? 2'd2 : rr - 2'd1;
            if (req[c0])
                win = c0;
            else if (req[c1])
                win = c1;
            else
                win = c2;
        end
`endif
    end

    assign win_addr = req_addr[win*CB_AW +: CB_AW];
    assign win_len  = req_len[win*LEN_W +: LEN_W];
    assign win_dir  = req_dir[win*2 +: 2];

    // Main sequencer; all outputs it drives are registered.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            rr       <= 2'd0;
            w_q      <= 2'd0;
            base_q   <= '0;
            len_q    <= '0;
            dir_q    <= 2'd0;
            cnt      <= '0;
            dcnt     <= '0;
            gnt      <= 3'd0;
            done     <= 3'd0;
            CB_ena   <= 1'b0;
            CB_addra <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 3'd0;
                    if (win_vld) begin
                        w_q    <= win;
                        base_q <= win_addr;
                        len_q  <= win_len;
                        dir_q  <= win_dir;
                        gnt    <= 3'b001 << win;
                        cnt    <= '0;
                        if (win_len != '0) begin
                            state    <= BURST;
                            CB_ena   <= 1'b1;
                            CB_addra <= win_addr;
                        end else begin
                            // Zero-length: jump straight to the last drain
                            // cycle so gnt and done share a single cycle.
                            state <= DRAIN;
                            dcnt  <= DLAST;
                            done  <= 3'b001 << win;
                        end
                    end
                end
                BURST: begin
                    if (cnt == len_q - 1'b1) begin
                        state  <= DRAIN;
                        CB_ena <= 1'b0;
                        dcnt   <= '0;
                        done   <= (RD_LAT == 0) ? gnt : 3'd0;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        CB_addra <= base_q + CB_AW'(cnt + 1'b1);
                    end
                end
                DRAIN: begin
                    if (dcnt == DLAST) begin
                        state <= IDLE;
                        done  <= 3'd0;
                        gnt   <= 3'd0;
`ifdef CB_RD_SCHED_M_PRIO_EN
                        if (w_q != 2'd2)
                            rr <= (w_q == 2'd0) ? 2'd1 : 2'd0;
`else
                        rr <= (w_q == 2'd2) ? 2'd0 : w_q + 2'd1;
`endif
                    end else begin
                        dcnt <= dcnt + 1'b1;
                        // done is registered, so raise it entering the last cycle.
                        done <= (DW'(dcnt + 1'b1) == DLAST) ? gnt : 3'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select for the current read; zero whenever no read is issued.
    assign s0_sel = CB_ena ? {w_q + 2'd1, dir_q} : 4'd0;

    // Delay line: stage k holds the read issued k cycles ago.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 1; k <= RD_LAT + 1; k++)
                pipe[k] <= '0;
        end else begin
            pipe[1] <= '{vld: CB_ena, tgt: gnt, sel: s0_sel};
            for (int k = 2; k <= RD_LAT + 1; k++)
                pipe[k] <= pipe[k-1];
        end
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign CB_douta_sel = s0_sel;
        end else begin : g_latn
            assign CB_douta_sel = pipe[RD_LAT].sel;
        end
    endgenerate

    // Mapper output is registered: one stage beyond the read data.
    assign out_vld   = pipe[RD_LAT+1].vld ? pipe[RD_LAT+1].tgt : 3'd0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_cb_rd_sched.sv
module tb_cb_rd_sched;
    localparam int CB_AW  = 10;
    localparam int LEN_W  = 8;
    localparam int RD_LAT = 1;

    logic                 clk;
    logic                 sys_rst_n;
    logic [2:0]           req;
    logic [3*CB_AW-1:0]   req_addr;
    logic [3*LEN_W-1:0]   req_len;
    logic [5:0]           req_dir;
    logic [2:0]           gnt;
    logic [2:0]           done;
    logic                 CB_ena;
    logic [CB_AW-1:0]     CB_addra;
    logic [3:0]           CB_douta_sel;
    logic [2:0]           out_vld;
    logic                 busy;
    logic [1:0]           dbg_state;

    cb_rd_sched #(.CB_AW(CB_AW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .req          (req),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_dir      (req_dir),
        .gnt          (gnt),
        .done         (done),
        .CB_ena       (CB_ena),
        .CB_addra     (CB_addra),
        .CB_douta_sel (CB_douta_sel),
        .out_vld      (out_vld),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [CB_AW-1:0] exp_addr_q[$];
    logic [3:0]       exp_sel_q[$];
    logic [2:0]       exp_vld_q[$];
    logic [2:0]       exp_gnt_q[$];
    logic [3:0]       exp_done_q[$];   // {len nonzero, one-hot}
    logic             gap_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_txn(input int idx, input logic [CB_AW-1:0] addr, input int len,
                            input logic [1:0] dir);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        exp_gnt_q.push_back(oh);
        for (int k = 0; k < len; k++) begin
            exp_addr_q.push_back(addr + CB_AW'(k));
            exp_sel_q.push_back({2'(idx + 1), dir});
            exp_vld_q.push_back(oh);
        end
        exp_done_q.push_back({len != 0, oh});
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output.
    initial begin
        logic ena_d1, ena_d2, ena_prev, have_last;
        logic [2:0] gnt_prev;
        logic [3:0] de;
        int last_ena_cyc;
        ena_d1 = 0; ena_d2 = 0; ena_prev = 0; have_last = 0; gnt_prev = 0;
        last_ena_cyc = 0;
        forever begin
            @(negedge clk);
            if (!sys_rst_n) begin
                ena_d1 = 0; ena_d2 = 0; ena_prev = 0; have_last = 0; gnt_prev = 0;
                continue;
            end
            if (gnt != 3'd0 && gnt_prev == 3'd0) begin
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", gnt, 0);
                else chk("gnt", gnt, exp_gnt_q.pop_front());
            end
            if (CB_ena) begin
                if (exp_addr_q.size() == 0) chk("addr_unexpected", CB_addra, 0);
                else chk("addra", CB_addra, exp_addr_q.pop_front());
                if (!ena_prev && gap_chk && have_last)
                    chk("burst_gap", cyc - last_ena_cyc - 1, RD_LAT + 2);
                have_last = gap_chk;
                last_ena_cyc = cyc;
            end
            if (CB_douta_sel != 4'd0) begin
                if (exp_sel_q.size() == 0) chk("sel_unexpected", CB_douta_sel, 0);
                else chk("douta_sel", CB_douta_sel, exp_sel_q.pop_front());
            end
            if (CB_douta_sel != 4'd0 || ena_d1)
                chk("sel_align", CB_douta_sel != 4'd0, ena_d1);
            if (out_vld != 3'd0) begin
                if (exp_vld_q.size() == 0) chk("vld_unexpected", out_vld, 0);
                else chk("out_vld", out_vld, exp_vld_q.pop_front());
            end
            if (out_vld != 3'd0 || ena_d2)
                chk("vld_align", out_vld != 3'd0, ena_d2);
            if (done != 3'd0) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    de = exp_done_q.pop_front();
                    chk("done", done, de[2:0]);
                    chk("done_gnt", done, gnt);
                    if (de[3]) chk("done_last_vld", out_vld, de[2:0]);
                end
            end
            ena_d2 = ena_d1;
            ena_d1 = CB_ena;
            ena_prev = CB_ena;
            gnt_prev = gnt;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_fields(input int idx, input logic [CB_AW-1:0] addr, input int len,
                              input logic [1:0] dir);
        req_addr[idx*CB_AW +: CB_AW] = addr;
        req_len[idx*LEN_W +: LEN_W]  = LEN_W'(len);
        req_dir[idx*2 +: 2]          = dir;
    endtask

    task automatic wait_gnt_rise();
        logic [2:0] gp;
        bit ok;
        gp = gnt;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt != 3'd0 && gp == 3'd0) begin ok = 1; break; end
            gp = gnt;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL gnt_wait: no grant within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && exp_done_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_wait: still busy after 100 cycles (cycle %0d)", cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_one(input int idx, input logic [CB_AW-1:0] addr, input int len,
                           input logic [1:0] dir);
        push_txn(idx, addr, len, dir);
        set_fields(idx, addr, len, dir);
        req = 3'b001 << idx;
        wait_gnt_rise();
        req = 3'd0;
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        sys_rst_n = 1'b0;
        req = 3'd0; req_addr = '0; req_len = '0; req_dir = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_ena", CB_ena, 0);
        chk("rst_addra", CB_addra, 0);
        chk("rst_sel", CB_douta_sel, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // A: 0x010, len 4, dir POS -> sel 0101
        run_one(0, 10'h010, 4, 2'b01);
        // B wrap: 0x3FE..0x001, dir NEW_0 -> sel 1010
        run_one(1, 10'h3FE, 4, 2'b10);
        // M zero length: gnt and done in one cycle, no reads
        run_one(2, 10'h123, 0, 2'b01);

`ifndef CB_RD_SCHED_M_PRIO_EN
        // All three held, len 2: order A, B, M, A
        push_txn(0, 10'h100, 2, 2'b01);
        push_txn(1, 10'h200, 2, 2'b01);
        push_txn(2, 10'h300, 2, 2'b01);
        push_txn(0, 10'h100, 2, 2'b01);
        set_fields(0, 10'h100, 2, 2'b01);
        set_fields(1, 10'h200, 2, 2'b01);
        set_fields(2, 10'h300, 2, 2'b01);
        gap_chk = 1'b1;
        req = 3'b111;
        for (int g = 0; g < 4; g++) wait_gnt_rise();
        req = 3'd0;
        wait_idle();
        gap_chk = 1'b0;
`endif

        // dir IDLE, len 1: read still issues, sel 0100
        run_one(0, 10'h020, 1, 2'b00);

        // Reset during the 3rd read of an 8-word A burst
        push_txn(0, 10'h080, 2, 2'b01);
        exp_done_q.delete();
        set_fields(0, 10'h080, 8, 2'b01);
        req = 3'b001;
        wait_gnt_rise();
        req = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_rst_outputs",
            {gnt, done, CB_ena, CB_addra, CB_douta_sel, out_vld, busy}, 0);
        exp_addr_q.delete(); exp_sel_q.delete(); exp_vld_q.delete();
        exp_gnt_q.delete(); exp_done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(1, 10'h1F0, 3, 2'b11);

`ifdef CB_RD_SCHED_M_PRIO_EN
        // A running, M raised mid-burst: M wins over the waiting B
        push_txn(0, 10'h040, 4, 2'b01);
        push_txn(2, 10'h340, 2, 2'b01);
        push_txn(1, 10'h240, 2, 2'b01);
        set_fields(0, 10'h040, 4, 2'b01);
        set_fields(1, 10'h240, 2, 2'b01);
        set_fields(2, 10'h340, 2, 2'b01);
        req = 3'b011;
        wait_gnt_rise();
        @(posedge clk); #1;
        req = 3'b111;
        wait_gnt_rise();
        req = 3'b011;
        wait_gnt_rise();
        req = 3'd0;
        wait_idle();
`endif

        repeat (4) @(posedge clk);
        chk("leftover_expectations",
            exp_addr_q.size() + exp_sel_q.size() + exp_vld_q.size()
            + exp_gnt_q.size() + exp_done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
